instr_encoder: RTL and testbench

- Packs RV32I instruction fields (opcode, funct3, funct7, rd, rs1, rs2, full 32-bit immediate) into a 32-bit instruction word. This is the inverse of the core's field decoder.
- Used by the self-test program generator and the instruction-memory loader to stream legal encodings toward memory.
- Valid/ready input and output, with a small output FIFO.
- Flags immediates that cannot be represented in the selected format and keeps accept and error statistics.

---
 rtl/instr_encoder_pkg.sv | 51 +++++
 rtl/instr_encoder_pack.sv | 62 ++++++
 rtl/instr_encoder.sv | 110 +++++++++++
 tb/tb_instr_encoder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - RV32I opcode constants, instruction formats and range helpers
package instr_encoder_pkg;

   localparam logic [6:0] OP_REG   = 7'h33;
   localparam logic [6:0] OP_IMM   = 7'h13;
   localparam logic [6:0] OP_LOAD  = 7'h03;
   localparam logic [6:0] OP_JALR  = 7'h67;
   localparam logic [6:0] OP_CSR   = 7'h73;
   localparam logic [6:0] OP_STORE = 7'h23;
   localparam logic [6:0] OP_BR    = 7'h63;
   localparam logic [6:0] OP_LUI   = 7'h37;
   localparam logic [6:0] OP_AUIPC = 7'h17;
   localparam logic [6:0] OP_JAL   = 7'h6F;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_SHI,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_BAD
   } instr_fmt_t;

   function automatic instr_fmt_t fmt_of(input logic [6:0] opcode, input logic [2:0] funct3);
      instr_fmt_t fmt;
      fmt = FMT_BAD;
      case (opcode)
         OP_REG:                   fmt = FMT_R;
         OP_IMM:                   fmt = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SHI : FMT_I;
         OP_LOAD, OP_JALR, OP_CSR: fmt = FMT_I;
         OP_STORE:                 fmt = FMT_S;
         OP_BR:                    fmt = FMT_B;
         OP_LUI, OP_AUIPC:         fmt = FMT_U;
         OP_JAL:                   fmt = FMT_J;
         default:                  fmt = FMT_BAD;
      endcase
      return fmt;
   endfunction

   // True when v[31:lsb] are all copies of one bit, i.e. v fits a signed field ending at lsb.
   function automatic logic all_same(input logic [31:0] v, input int lsb);
      logic [31:0] s;
      s = 32'($signed(v) >>> lsb);
      return (s == '0) || (s == '1);
   endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// rtl/instr_encoder_pack.sv - combinational format select, field packing and immediate range check
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [6:0]  opcode_i,
   input  logic [2:0]  funct3_i,
   input  logic [6:0]  funct7_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [31:0] imm_i,
   output logic [31:0] word_o,
   output logic        err_o
);

   instr_fmt_t  fmt;
   logic [31:0] raw;
   logic        err;

   always_comb begin
      fmt = fmt_of(opcode_i, funct3_i);
      raw = '0;
      err = 1'b0;
      case (fmt)
         FMT_R: begin
            raw = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         end
         FMT_I: begin
            raw = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            err = !all_same(imm_i, 11);
         end
         FMT_SHI: begin
            raw = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
            err = (imm_i[31:5] != '0);
         end
         FMT_S: begin
            raw = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            err = !all_same(imm_i, 11);
         end
         FMT_B: begin
            raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], opcode_i};
            err = !all_same(imm_i, 12) || imm_i[0];
         end
         FMT_U: begin
            raw = {imm_i[31:12], rd_i, opcode_i};
            err = (imm_i[11:0] != '0);
         end
         FMT_J: begin
            raw = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            err = !all_same(imm_i, 20) || imm_i[0];
         end
         default: begin
            raw = '0;
            err = 1'b1;
         end
      endcase
   end

   assign word_o = err ? INSTR_NOP : raw;
   assign err_o  = err;

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I field encoder with output FIFO, sticky error and accept counter
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_opcode,
   input  logic [2:0]       in_funct3,
   input  logic [6:0]       in_funct7,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic             err_sticky,
   input  logic             clr_err,
   output logic [CNT_W-1:0] instr_count
);

   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] OCC_FULL = (AW + 1)'(DEPTH);

   logic [31:0]      pack_word;
   logic             pack_err;

   logic [31:0]      word_mem_q [DEPTH];
   logic [DEPTH-1:0] err_mem_q;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      occ_q, occ_d;
   logic             err_sticky_q, err_sticky_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push, pop;

   instr_pack u_pack (
      .opcode_i (in_opcode),
      .funct3_i (in_funct3),
      .funct7_i (in_funct7),
      .rd_i     (in_rd),
      .rs1_i    (in_rs1),
      .rs2_i    (in_rs2),
      .imm_i    (in_imm),
      .word_o   (pack_word),
      .err_o    (pack_err)
   );

   // Handshake depends on registered occupancy only, so a full FIFO refuses input even while popping.
   assign in_ready  = (occ_q < OCC_FULL);
   assign out_valid = (occ_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign out_instr   = out_valid ? word_mem_q[rd_ptr_q] : '0;
   assign out_err     = out_valid && err_mem_q[rd_ptr_q];
   assign err_sticky  = err_sticky_q;
   assign instr_count = count_q;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      occ_d        = occ_q + (AW + 1)'(push) - (AW + 1)'(pop);
      err_sticky_d = err_sticky_q;
      count_d      = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         count_d  = count_q + CNT_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && pack_err) begin
         err_sticky_d = 1'b1;
      end else if (clr_err) begin
         err_sticky_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         occ_q        <= '0;
         err_sticky_q <= 1'b0;
         count_q      <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         occ_q        <= occ_d;
         err_sticky_q <= err_sticky_d;
         count_q      <= count_d;
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         word_mem_q[wr_ptr_q] <= pack_word;
         err_mem_q[wr_ptr_q]  <= pack_err;
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   typedef struct packed {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } fld_t;

   typedef struct {
      fld_t        f;
      logic [31:0] w;
      logic        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_opcode = '0;
   logic [2:0]  in_funct3 = '0;
   logic [6:0]  in_funct7 = '0;
   logic [4:0]  in_rd = '0;
   logic [4:0]  in_rs1 = '0;
   logic [4:0]  in_rs2 = '0;
   logic [31:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic        out_err;
   logic        err_sticky;
   logic        clr_err = 1'b0;
   logic [15:0] instr_count;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   instr_encoder #(.DEPTH(2), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
      .err_sticky(err_sticky), .clr_err(clr_err), .instr_count(instr_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic fld_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm);
      fld_t f;
      f = '{op: op, f3: f3, f7: f7, rd: rd, rs1: rs1, rs2: rs2, imm: imm};
      return f;
   endfunction

   task automatic drive(input fld_t f);
      in_opcode = f.op; in_funct3 = f.f3; in_funct7 = f.f7;
      in_rd = f.rd; in_rs1 = f.rs1; in_rs2 = f.rs2; in_imm = f.imm;
   endtask

   function automatic logic is_shift(input fld_t f);
      return f.op == OP_IMM && (f.f3 == 3'd1 || f.f3 == 3'd5);
   endfunction

   // Legality from numeric ranges of each format.
   function automatic logic legal(input fld_t f);
      int s;
      s = $signed(f.imm);
      case (f.op)
         OP_REG: return 1'b1;
         OP_IMM, OP_LOAD, OP_JALR, OP_CSR, OP_STORE:
            if (is_shift(f)) return f.imm <= 32'd31;
            else return s >= -2048 && s <= 2047;
         OP_BR:  return s >= -4096 && s <= 4094 && (s % 2 == 0);
         OP_LUI, OP_AUIPC: return (f.imm & 32'hFFF) == 0;
         OP_JAL: return s >= -(1 << 20) && s <= (1 << 20) - 2 && (s % 2 == 0);
         default: return 1'b0;
      endcase
   endfunction

   // Reference decoder: recovers fields from a word; fields a format lacks come back as 0.
   function automatic fld_t decode(input logic [31:0] w);
      fld_t d;
      d = '0;
      d.op = w[6:0];
      case (d.op)
         OP_REG: begin
            d.f7 = w[31:25]; d.rs2 = w[24:20]; d.rs1 = w[19:15]; d.f3 = w[14:12]; d.rd = w[11:7];
         end
         OP_IMM, OP_LOAD, OP_JALR, OP_CSR: begin
            d.rs1 = w[19:15]; d.f3 = w[14:12]; d.rd = w[11:7];
            if (d.op == OP_IMM && (d.f3 == 3'd1 || d.f3 == 3'd5)) begin
               d.f7 = w[31:25]; d.imm = {27'b0, w[24:20]};
            end else begin
               d.imm = {{20{w[31]}}, w[31:20]};
            end
         end
         OP_STORE: begin
            d.rs2 = w[24:20]; d.rs1 = w[19:15]; d.f3 = w[14:12];
            d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
         end
         OP_BR: begin
            d.rs2 = w[24:20]; d.rs1 = w[19:15]; d.f3 = w[14:12];
            d.imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            d.rd = w[11:7]; d.imm = {w[31:12], 12'b0};
         end
         OP_JAL: begin
            d.rd = w[11:7];
            d.imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
         end
         default: d = '0;
      endcase
      return d;
   endfunction

   function automatic fld_t expect_of(input fld_t r);
      fld_t e;
      e = r;
      case (r.op)
         OP_REG: e.imm = '0;
         OP_IMM, OP_LOAD, OP_JALR, OP_CSR: begin
            e.rs2 = '0;
            if (!is_shift(r)) e.f7 = '0;
         end
         OP_STORE, OP_BR: begin e.rd = '0; e.f7 = '0; end
         default: begin e.f3 = '0; e.rs1 = '0; e.rs2 = '0; e.f7 = '0; end
      endcase
      return e;
   endfunction

   task automatic gen(output fld_t r);
      logic [6:0] ops [11];
      logic [31:0] u;
      int k;
      ops = '{OP_REG, OP_IMM, OP_LOAD, OP_JALR, OP_CSR, OP_STORE, OP_BR, OP_LUI, OP_AUIPC, OP_JAL, 7'h7F};
      k = int'($urandom_range(0, 10));
      r.op = ops[k];
      r.f3 = 3'($urandom); r.f7 = 7'($urandom);
      r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
      u = $urandom;
      case (r.op)
         OP_IMM, OP_LOAD, OP_JALR, OP_CSR, OP_STORE:
            if (is_shift(r)) r.imm = $urandom_range(0, 31);
            else r.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
         OP_BR:  r.imm = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
         OP_LUI, OP_AUIPC: r.imm = {u[19:0], 12'b0};
         OP_JAL: r.imm = 32'((int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19)) * 2);
         default: r.imm = u;
      endcase
      if ($urandom_range(0, 7) == 0) r.imm = $urandom;
   endtask

   vec_t vecs [18];
   fld_t sb [$];
   fld_t cur, head, de;
   int accepted;
   logic pending;

   initial begin
      vecs[0]  = '{mk(OP_IMM,   3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF), 32'hFFF1_0093, 1'b0};
      vecs[1]  = '{mk(OP_BR,    3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC), 32'hFE20_8EE3, 1'b0};
      vecs[2]  = '{mk(OP_LUI,   3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000), 32'h1234_52B7, 1'b0};
      vecs[3]  = '{mk(OP_JAL,   3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd3),         32'h0000_0013, 1'b1};
      vecs[4]  = '{mk(OP_REG,   3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0),         32'h0020_81B3, 1'b0};
      vecs[5]  = '{mk(OP_IMM,   3'd5, 7'h20, 5'd1, 5'd2, 5'd0, 32'd31),        32'h41F1_5093, 1'b0};
      vecs[6]  = '{mk(OP_IMM,   3'd1, 7'h00, 5'd1, 5'd2, 5'd0, 32'd32),        32'h0000_0013, 1'b1};
      vecs[7]  = '{mk(OP_IMM,   3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2047),      32'h7FF0_0093, 1'b0};
      vecs[8]  = '{mk(OP_IMM,   3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048),      32'h0000_0013, 1'b1};
      vecs[9]  = '{mk(OP_IMM,   3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800), 32'h8000_0093, 1'b0};
      vecs[10] = '{mk(OP_STORE, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC), 32'hFE20_AE23, 1'b0};
      vecs[11] = '{mk(OP_LUI,   3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5001), 32'h0000_0013, 1'b1};
      vecs[12] = '{mk(OP_BR,    3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3),         32'h0000_0013, 1'b1};
      vecs[13] = '{mk(7'h7F,    3'd0, 7'h00, 5'd1, 5'd1, 5'd1, 32'd0),         32'h0000_0013, 1'b1};
      vecs[14] = '{mk(OP_JAL,   3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048),      32'h0010_00EF, 1'b0};
      vecs[15] = '{mk(OP_JALR,  3'd0, 7'h00, 5'd0, 5'd1, 5'd0, 32'd0),         32'h0000_8067, 1'b0};
      vecs[16] = '{mk(OP_BR,    3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4096),      32'h0000_0013, 1'b1};
      vecs[17] = '{mk(OP_AUIPC, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'hFFFF_F000), 32'hFFFF_F097, 1'b0};

      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_instr", out_instr, 0);
      check("rst_out_err", out_err, 0);
      check("rst_err_sticky", err_sticky, 0);
      check("rst_instr_count", instr_count, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(vecs[i].f);
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         check($sformatf("vec%0d_valid", i), out_valid, 1);
         check($sformatf("vec%0d_word", i), out_instr, vecs[i].w);
         check($sformatf("vec%0d_err", i), out_err, vecs[i].e);
      end
      check("table_count", instr_count, 18);
      check("table_sticky", err_sticky, 1);

      @(negedge clk); clr_err = 1'b1;
      @(posedge clk); #1; clr_err = 1'b0;
      check("clr_sticky", err_sticky, 0);
      @(negedge clk); drive(vecs[3].f); in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      check("bad_sticky", err_sticky, 1);
      check("bad_word", out_instr, 32'h13);
      check("bad_err", out_err, 1);
      check("bad_count", instr_count, 19);
      @(negedge clk); drive(vecs[12].f); in_valid = 1'b1; clr_err = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0; clr_err = 1'b0;
      check("set_wins_sticky", err_sticky, 1);
      check("set_wins_count", instr_count, 20);
      @(negedge clk); clr_err = 1'b1;
      @(posedge clk); #1; clr_err = 1'b0;
      check("clr2_sticky", err_sticky, 0);
      check("drained_before_bp", out_valid, 0);

      @(negedge clk); out_ready = 1'b0; drive(vecs[0].f); in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk); drive(vecs[1].f);
      @(posedge clk);
      @(negedge clk); drive(vecs[2].f);
      #1;
      check("full_in_ready", in_ready, 0);
      check("stall_head", out_instr, 32'hFFF1_0093);
      @(posedge clk); #1;
      check("full_hold_ready", in_ready, 0);
      check("full_count", instr_count, 22);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      check("pop1_in_ready", in_ready, 1);
      check("pop1_head", out_instr, 32'hFE20_8EE3);
      check("pop1_count", instr_count, 22);
      @(posedge clk); #1; in_valid = 1'b0;
      check("pop2_head", out_instr, 32'h1234_52B7);
      check("pop2_count", instr_count, 23);
      @(posedge clk); #1;
      check("bp_drained", out_valid, 0);

      @(negedge clk); out_ready = 1'b0; drive(vecs[0].f); in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk); drive(vecs[1].f);
      @(posedge clk); #1; in_valid = 1'b0;
      check("pre_rst_valid", out_valid, 1);
      #2; rst_n = 1'b0; #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_count", instr_count, 0);
      check("arst_out_instr", out_instr, 0);
      @(negedge clk); rst_n = 1'b1;

      accepted = 0;
      pending = 1'b0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         @(negedge clk);
         if (accepted >= 1000 && sb.size() == 0 && !pending) break;
         if (!pending) begin
            if (accepted < 1000 && $urandom_range(0, 3) != 0) begin
               gen(cur); drive(cur); in_valid = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL rnd_unexpected_pop: got %h expected none", out_instr);
            end else begin
               head = sb.pop_front();
               check("rnd_err", out_err, !legal(head));
               if (!legal(head)) begin
                  check("rnd_nop", out_instr, 32'h13);
               end else begin
                  de = decode(out_instr);
                  check("rnd_fields", de, expect_of(head));
               end
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back(cur);
            accepted++;
            pending = 1'b0;
         end else begin
            pending = in_valid;
         end
      end
      in_valid = 1'b0;
      check("rnd_accepted", accepted, 1000);
      check("rnd_sb_empty", sb.size(), 0);
      check("rnd_count", instr_count, 16'(accepted));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
